// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller and its helpers.
// Optional statistics counters are enabled by defining PLL_LOCK_STATS_EN.
package pll_ctrl_pkg;

  // Controller states: pulse PLL reset, wait for lock, qualify lock, run.
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // Width and saturation value of the retry/loss statistics counters.
  localparam int              STAT_W   = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;

  // Default timing parameters, in refclk cycles.
  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;

  // Largest of three values; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic 2-flop synchronizer with asynchronous active-high reset to 0.
// Brings a signal from another clock domain into the clk domain.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock controller on the free-running reference clock.
// Pulses the PLL reset, qualifies lock for a stable window, then releases
// the system reset. Re-pulses the PLL on lock timeout and on lock loss.
// ready is a level status (high only in RUN), not a handshake.
// dbg_state exposes the current controller state for observation.
// Define PLL_LOCK_STATS_EN to build the retry/loss counters; otherwise both
// count ports are tied to zero and no counter registers exist.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic [STAT_W-1:0] retry_cnt,
  output logic [STAT_W-1:0] loss_cnt,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W =
    $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

  // Terminal counts: the counter starts at 0, so the last cycle is N-1.
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pll_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             w_lk;

  // pll_locked is asynchronous to refclk; the FSM only ever sees w_lk.
  sync2 #(.W(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (w_lk)
  );

  // Controller FSM with one shared cycle counter and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= RESET_PLL;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == RP_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (w_lk) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_state   <= RESET_PLL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE: begin
          // A dropout wins over completion and restarts both qualification
          // and the lock timeout.
          if (!w_lk) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == LS_LAST) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!w_lk) begin
            r_state   <= RESET_PLL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state   <= RESET_PLL;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign dbg_state = r_state;

`ifdef PLL_LOCK_STATS_EN
  logic [STAT_W-1:0] r_retry_cnt;
  logic [STAT_W-1:0] r_loss_cnt;
  logic              w_retry_evt;
  logic              w_loss_evt;

  // Same conditions that send the FSM back to RESET_PLL.
  assign w_retry_evt = (r_state == WAIT_LOCK) && !w_lk && (r_cnt == TO_LAST);
  assign w_loss_evt  = (r_state == RUN) && !w_lk;

  // Saturating event counters; they hold at STAT_MAX instead of wrapping.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      if (w_retry_evt && (r_retry_cnt != STAT_MAX)) r_retry_cnt <= r_retry_cnt + 1'b1;
      if (w_loss_evt && (r_loss_cnt != STAT_MAX))   r_loss_cnt  <= r_loss_cnt + 1'b1;
    end
  end

  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;
`else
  assign retry_cnt = '0;
  assign loss_cnt  = '0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl with RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
// Expected values come from the timing rules: reset pulse length, the
// 3-edge synchronizer+FSM delay, stable window, timeout period, saturation.
module tb_pll_lock_ctrl;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int TO = 32;
  localparam int REL = LS + 3;   // edges from lock rise to sys_rst release
  localparam int PER = RP + TO;  // timeout retry period

`ifdef PLL_LOCK_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [1:0] dbg_state;

  int n_pass;
  int n_total;

  pll_lock_ctrl #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (TO)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  // Driver tasks
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Reset, release on a falling edge, and run out the PLL reset pulse.
  task automatic reset_to_wait();
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    @(negedge refclk);
    rst = 1'b0;
    repeat (RP) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    n_total++;
    if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 ||
        retry_cnt !== 8'd0 || loss_cnt !== 8'd0 || dbg_state !== 2'd0)
      $display("FAIL reset: pll_rst=%b sys_rst=%b ready=%b retry=%0d loss=%0d st=%0d, want 1 1 0 0 0 0",
               pll_rst, sys_rst, ready, retry_cnt, loss_cnt, dbg_state);
    else n_pass++;
  endtask

  task automatic test_power_up();
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    @(negedge refclk);
    rst = 1'b0;
    for (int k = 1; k <= RP + 2; k++) begin
      tick();
      n_total++;
      if (pll_rst !== (k < RP) || sys_rst !== 1'b1 || ready !== 1'b0)
        $display("FAIL power_up edge %0d: pll_rst=%b sys_rst=%b ready=%b, want %b 1 0",
                 k, pll_rst, sys_rst, ready, (k < RP));
      else n_pass++;
    end
  endtask

  task automatic test_clean_lock(input int d);
    reset_to_wait();
    repeat (d) tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      tick();
      n_total++;
      if (sys_rst !== (k < REL) || ready !== (k == REL) || pll_rst !== 1'b0)
        $display("FAIL clean_lock d=%0d edge %0d: sys_rst=%b ready=%b pll_rst=%b, want %b %b 0",
                 d, k, sys_rst, ready, pll_rst, (k < REL), (k == REL));
      else n_pass++;
    end
    n_total++;
    if (dbg_state !== 2'd3)
      $display("FAIL clean_lock_state: state=%0d, want 3", dbg_state);
    else n_pass++;
  endtask

  // Lock for s edges, drop for g edges, re-lock; release timed from re-lock.
  task automatic test_glitch(input int s, input int g);
    reset_to_wait();
    pll_locked = 1'b1;
    for (int k = 1; k <= s + g; k++) begin
      if (k == s + 1) pll_locked = 1'b0;
      tick();
      n_total++;
      if (sys_rst !== 1'b1 || ready !== 1'b0)
        $display("FAIL glitch_hold s=%0d g=%0d edge %0d: sys_rst=%b ready=%b, want 1 0",
                 s, g, k, sys_rst, ready);
      else n_pass++;
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      tick();
      n_total++;
      if (sys_rst !== (k < REL) || ready !== (k == REL) || pll_rst !== 1'b0)
        $display("FAIL glitch_relock s=%0d g=%0d edge %0d: sys_rst=%b ready=%b pll_rst=%b, want %b %b 0",
                 s, g, k, sys_rst, ready, pll_rst, (k < REL), (k == REL));
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_r;
    logic       exp_p;
    reset_to_wait();
    for (int k = 1; k <= 3 * PER; k++) begin
      tick();
      exp_p = ((k % PER) >= TO);
      exp_r = STATS_ON ? 8'((k + RP) / PER) : 8'd0;
      n_total++;
      if (pll_rst !== exp_p || retry_cnt !== exp_r || sys_rst !== 1'b1 || ready !== 1'b0)
        $display("FAIL timeout edge %0d: pll_rst=%b retry=%0d sys_rst=%b ready=%b, want %b %0d 1 0",
                 k, pll_rst, retry_cnt, sys_rst, ready, exp_p, exp_r);
      else n_pass++;
    end
  endtask

  task automatic test_loss();
    int         hold;
    logic [7:0] exp_l;
    reset_to_wait();
    pll_locked = 1'b1;
    repeat (REL) tick();
    hold = $urandom_range(0, 10);
    for (int k = 0; k < hold; k++) begin
      tick();
      n_total++;
      if (ready !== 1'b1 || sys_rst !== 1'b0)
        $display("FAIL run_hold cycle %0d: ready=%b sys_rst=%b, want 1 0", k, ready, sys_rst);
      else n_pass++;
    end
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_l = (STATS_ON && k == 3) ? 8'd1 : 8'd0;
      n_total++;
      if (sys_rst !== (k == 3) || pll_rst !== (k == 3) || ready !== (k < 3) || loss_cnt !== exp_l)
        $display("FAIL loss edge %0d: sys_rst=%b pll_rst=%b ready=%b loss=%0d, want %b %b %b %0d",
                 k, sys_rst, pll_rst, ready, loss_cnt, (k == 3), (k == 3), (k < 3), exp_l);
      else n_pass++;
    end
    for (int n = 2; n <= 300; n++) begin
      repeat (RP) tick();
      pll_locked = 1'b1;
      repeat (REL) tick();
      n_total++;
      if (ready !== 1'b1)
        $display("FAIL loss_relock n=%0d: ready=%b, want 1", n, ready);
      else n_pass++;
      pll_locked = 1'b0;
      repeat (3) tick();
      exp_l = STATS_ON ? ((n > 255) ? 8'd255 : 8'(n)) : 8'd0;
      n_total++;
      if (loss_cnt !== exp_l || sys_rst !== 1'b1)
        $display("FAIL loss_count n=%0d: loss=%0d sys_rst=%b, want %0d 1", n, loss_cnt, sys_rst, exp_l);
      else n_pass++;
    end
    n_total++;
    if (retry_cnt !== 8'd0)
      $display("FAIL loss_retry: retry=%0d, want 0", retry_cnt);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    reset_to_wait();
    pll_locked = 1'b1;
    repeat (REL) tick();
    pll_locked = 1'b0;
    repeat (3 + RP) tick();
    pll_locked = 1'b1;
    repeat (REL) tick();
    n_total++;
    if (ready !== 1'b1 || loss_cnt !== (STATS_ON ? 8'd1 : 8'd0))
      $display("FAIL midrun_pre: ready=%b loss=%0d, want 1 %0d", ready, loss_cnt, (STATS_ON ? 1 : 0));
    else n_pass++;
    @(posedge refclk);
    #7 rst = 1'b1;
    #1;
    n_total++;
    if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 ||
        retry_cnt !== 8'd0 || loss_cnt !== 8'd0 || dbg_state !== 2'd0)
      $display("FAIL midrun_async: pll_rst=%b sys_rst=%b ready=%b retry=%0d loss=%0d st=%0d, want 1 1 0 0 0 0",
               pll_rst, sys_rst, ready, retry_cnt, loss_cnt, dbg_state);
    else n_pass++;
    @(negedge refclk);
    rst = 1'b0;
    // Lock held through reset: synchronizer refills, then RP + 1 + LS edges.
    for (int k = 1; k <= RP + 1 + LS; k++) begin
      tick();
      n_total++;
      if (pll_rst !== (k < RP) || sys_rst !== (k < RP + 1 + LS) || ready !== (k == RP + 1 + LS))
        $display("FAIL midrun_restart edge %0d: pll_rst=%b sys_rst=%b ready=%b, want %b %b %b",
                 k, pll_rst, sys_rst, ready, (k < RP), (k < RP + 1 + LS), (k == RP + 1 + LS));
      else n_pass++;
    end
  endtask

  // Sequence and final report
  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_power_up();
    test_clean_lock(0);
    test_clean_lock($urandom_range(1, 20));
    test_glitch(5, 2);
    test_glitch(LS, 1);
    test_glitch(LS, 3);
    test_glitch($urandom_range(1, LS), $urandom_range(1, 4));
    test_timeout();
    test_loss();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
